// File: rtl/wing_butled_ctrl_if.sv
// Wing bus between board pins, the dut and the button/LED controller.
// CHANNELS and PWM_BITS must match the values given to the controller.
interface wing_butled_ctrl_if #(
  parameter int CHANNELS = 4,
  parameter int PWM_BITS = 8
);
  logic [CHANNELS-1:0]          btn_raw;
  logic [CHANNELS-1:0]          buttons;
  logic [CHANNELS-1:0]          btn_press;
  logic [CHANNELS-1:0]          btn_release;
  logic [2*CHANNELS-1:0]        led_mode;
  logic [PWM_BITS*CHANNELS-1:0] led_duty;
  logic [CHANNELS-1:0]          led_pad;

  // Pins/dut side: drives raw buttons and LED requests, sees clean results.
  modport master (
    output btn_raw, led_mode, led_duty,
    input  buttons, btn_press, btn_release, led_pad
  );

  // Controller side.
  modport slave (
    input  btn_raw, led_mode, led_duty,
    output buttons, btn_press, btn_release, led_pad
  );
endinterface

// File: rtl/wing_butled_ctrl.sv
// Button/LED wing controller: per channel a 2-flop synchroniser, a restart-on-
// bounce debouncer with registered press/release pulses, and an LED driver
// selecting off/on/PWM/follow-button. PWM uses one shared prescaler and phase
// counter; duty is shadowed at the period boundary so a period never glitches.
module wing_butled_ctrl #(
  parameter int CHANNELS          = 4,
  parameter int DEBOUNCE_CYCLES   = 320000,
  parameter int PWM_BITS          = 8,
  parameter int PWM_DIV           = 125,
  parameter int BUTTON_ACTIVE_LOW = 0,
  parameter int LED_ACTIVE_LOW    = 0
) (
  input  logic            clk,
  input  logic            reset,
  wing_butled_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PWM_DIV - 1);
  localparam logic [PWM_BITS-1:0] PHASE_MAX = {PWM_BITS{1'b1}};
  localparam logic                BTN_INV   = (BUTTON_ACTIVE_LOW != 0);
  localparam logic                LED_INV   = (LED_ACTIVE_LOW != 0);

  logic [CHANNELS-1:0]          r_sync1;
  logic [CHANNELS-1:0]          r_sync2;
  logic [CNT_W-1:0]             r_cnt [CHANNELS];
  logic [CHANNELS-1:0]          r_stable;
  logic [CHANNELS-1:0]          r_buttons;
  logic [CHANNELS-1:0]          r_press;
  logic [CHANNELS-1:0]          r_release;
  logic [PRE_W-1:0]             r_pre;
  logic [PWM_BITS-1:0]          r_phase;
  logic [PWM_BITS*CHANNELS-1:0] r_shadow;
  logic [CHANNELS-1:0]          r_led;
  logic                         w_tick;
  logic [CHANNELS-1:0]          w_lit;

  // Normalise polarity to 1 = pressed, then bring raw pins into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.btn_raw ^ {CHANNELS{BTN_INV}};
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a new level only after it has differed from the stable
  // level for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (r_sync2[i] != r_stable[i]) begin
          if (r_cnt[i] == CNT_LAST) begin
            r_stable[i] <= r_sync2[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i]    <= r_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Publish the debounced level with press/release pulses aligned to its change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buttons <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_buttons <= r_stable;
      r_press   <= r_stable & ~r_buttons;
      r_release <= ~r_stable & r_buttons;
    end
  end

  assign w_tick = (r_pre == PRE_LAST);

  // Shared PWM timebase: prescaler wraps at PWM_DIV, phase advances on each tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre   <= '0;
      r_phase <= '0;
    end else if (w_tick) begin
      r_pre   <= '0;
      r_phase <= r_phase + PWM_BITS'(1);
    end else begin
      r_pre   <= r_pre + PRE_W'(1);
    end
  end

  // Duty shadow reloads only as the phase wraps, keeping each period intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
    end else if (w_tick && (r_phase == PHASE_MAX)) begin
      r_shadow <= bus.led_duty;
    end else begin
      r_shadow <= r_shadow;
    end
  end

  // Per-channel lit decision from the requested mode.
  always_comb begin
    w_lit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (bus.led_mode[2*i +: 2])
        2'b00:   w_lit[i] = 1'b0;
        2'b01:   w_lit[i] = 1'b1;
        2'b10:   w_lit[i] = (r_phase < r_shadow[PWM_BITS*i +: PWM_BITS]);
        2'b11:   w_lit[i] = r_buttons[i];
        default: w_lit[i] = 1'b0;
      endcase
    end
  end

  // Register the pad drive with the board's LED polarity applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led <= {CHANNELS{LED_INV}};
    end else begin
      r_led <= w_lit ^ {CHANNELS{LED_INV}};
    end
  end

  assign bus.buttons     = r_buttons;
  assign bus.btn_press   = r_press;
  assign bus.btn_release = r_release;
  assign bus.led_pad     = r_led;

endmodule

// File: tb/tb_wing_butled_ctrl.sv
// Bench for wing_butled_ctrl: CHANNELS=4, DEBOUNCE_CYCLES=8, PWM_BITS=4,
// PWM_DIV=2. Button events are queued when raw pins change and matched by a
// monitor whenever a press/release pulse appears; LED behaviour is checked
// directly. A second instance exercises inverted pin polarity.
module tb_wing_butled_ctrl;

  typedef struct {
    int         edge_n;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] btns;
  } ev_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  sb_q[$];

  wing_butled_ctrl_if #(.CHANNELS(4), .PWM_BITS(4)) bus ();
  wing_butled_ctrl_if #(.CHANNELS(4), .PWM_BITS(4)) bus2 ();

  wing_butled_ctrl #(
    .CHANNELS(4), .DEBOUNCE_CYCLES(8), .PWM_BITS(4), .PWM_DIV(2),
    .BUTTON_ACTIVE_LOW(0), .LED_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  wing_butled_ctrl #(
    .CHANNELS(4), .DEBOUNCE_CYCLES(8), .PWM_BITS(4), .PWM_DIV(2),
    .BUTTON_ACTIVE_LOW(1), .LED_ACTIVE_LOW(1)
  ) dut_inv (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (edge %0d)", name, got, exp, cyc);
    end
  endtask

  // Raw change applied now is first sampled on the next edge; result 10 edges later.
  task automatic push_ev(input logic [3:0] p, input logic [3:0] r, input logic [3:0] b);
    ev_t e;
    e.edge_n = cyc + 11;
    e.press  = p;
    e.rel    = r;
    e.btns   = b;
    sb_q.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_n(3);
    reset = 1'b0;
  endtask

  task automatic count_period(input int start, input int chg_i, input logic [3:0] chg_duty,
                              output int n);
    n = 0;
    while (cyc < start) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      if (i == chg_i) bus.led_duty[11:8] = chg_duty;
      n += int'(bus.led_pad[2]);
      @(negedge clk);
    end
  endtask

  // Monitor: every press/release pulse must match the next queued event.
  always @(negedge clk) begin
    ev_t e;
    if (!reset && ((bus.btn_press | bus.btn_release) != 4'h0)) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: edge %0d press %h release %h, required no event",
                 cyc, bus.btn_press, bus.btn_release);
      end else begin
        e = sb_q.pop_front();
        if (cyc != e.edge_n || bus.btn_press !== e.press || bus.btn_release !== e.rel ||
            bus.buttons !== e.btns) begin
          n_bad++;
          $display("FAIL btn_event: got edge %0d press %h release %h buttons %h, required edge %0d press %h release %h buttons %h",
                   cyc, bus.btn_press, bus.btn_release, bus.buttons,
                   e.edge_n, e.press, e.rel, e.btns);
        end
      end
    end
  end

  initial begin
    int         n;
    int         base;
    int         got_edge;
    int         exp_edge;
    logic [3:0] got_press;
    logic       prev_b3;

    reset          = 1'b1;
    bus.btn_raw    = 4'hF;
    bus.led_mode   = 8'h00;
    bus.led_duty   = 16'h0000;
    bus2.btn_raw   = 4'hF;
    bus2.led_mode  = 8'h00;
    bus2.led_duty  = 16'h0000;

    // 1. Reset held 3 cycles with all buttons raw-pressed.
    repeat (3) begin
      @(negedge clk);
      check("rst_buttons", {28'd0, bus.buttons}, 32'd0);
      check("rst_press",   {28'd0, bus.btn_press}, 32'd0);
      check("rst_release", {28'd0, bus.btn_release}, 32'd0);
      check("rst_led_pad", {28'd0, bus.led_pad}, 32'd0);
      check("rst_inv_led_pad", {28'd0, bus2.led_pad}, 32'h0000000F);
    end
    reset = 1'b0;
    push_ev(4'hF, 4'h0, 4'hF);
    wait_n(14);
    bus.btn_raw = 4'h0;
    push_ev(4'h0, 4'hF, 4'h0);
    wait_n(14);

    // 2. Clean press and release on channel 0.
    bus.btn_raw[0] = 1'b1;
    push_ev(4'h1, 4'h0, 4'h1);
    wait_n(14);
    bus.btn_raw[0] = 1'b0;
    push_ev(4'h0, 4'h1, 4'h0);
    wait_n(14);

    // 3. Bouncing channel 1: no event until a full stable window follows the last edge.
    for (int i = 0; i < 10; i++) begin
      bus.btn_raw[1] = ~bus.btn_raw[1];
      wait_n(3);
    end
    check("bounce_no_press", {28'd0, bus.buttons}, 32'd0);
    bus.btn_raw[1] = 1'b1;
    push_ev(4'h2, 4'h0, 4'h2);
    wait_n(14);

    // Reset part-way through a debounce throws the progress away.
    bus.btn_raw = 4'h0;
    do_reset();
    bus.btn_raw[1] = 1'b1;
    wait_n(6);
    reset = 1'b1;
    wait_n(1);
    reset = 1'b0;
    check("abort_buttons", {28'd0, bus.buttons}, 32'd0);
    push_ev(4'h2, 4'h0, 4'h2);
    wait_n(14);

    // 4. PWM on channel 2, duty shadowed at period boundaries.
    bus.btn_raw = 4'h0;
    do_reset();
    base = cyc;
    bus.led_mode[5:4]  = 2'b10;
    bus.led_duty[11:8] = 4'd4;
    count_period(base + 1,   -1, 4'd0,  n); check("pwm_p0_shadow0", n, 0);
    count_period(base + 33,  -1, 4'd0,  n); check("pwm_p1_duty4", n, 8);
    count_period(base + 65,  10, 4'd12, n); check("pwm_p2_midchange", n, 8);
    count_period(base + 97,  -1, 4'd0,  n); check("pwm_p3_duty12", n, 24);
    count_period(base + 129,  5, 4'd0,  n); check("pwm_p4_midchange", n, 24);
    count_period(base + 161, -1, 4'd0,  n); check("pwm_p5_duty0", n, 0);

    // 5. Constant modes on channel 0.
    bus.led_mode[1:0] = 2'b01;
    wait_n(1);
    check("mode_on_1", {31'd0, bus.led_pad[0]}, 32'd1);
    wait_n(4);
    check("mode_on_2", {31'd0, bus.led_pad[0]}, 32'd1);
    bus.led_mode[1:0] = 2'b00;
    wait_n(1);
    check("mode_off", {31'd0, bus.led_pad[0]}, 32'd0);

    // 6. All channels pressed together; channel 3 LED follows its button one cycle late.
    bus.led_mode[7:6] = 2'b11;
    bus.btn_raw = 4'hF;
    push_ev(4'hF, 4'h0, 4'hF);
    for (int i = 0; i < 14; i++) begin
      prev_b3 = bus.buttons[3];
      @(negedge clk);
      check("follow_press", {31'd0, bus.led_pad[3]}, {31'd0, prev_b3});
    end
    bus.btn_raw = 4'h0;
    push_ev(4'h0, 4'hF, 4'h0);
    for (int i = 0; i < 14; i++) begin
      prev_b3 = bus.buttons[3];
      @(negedge clk);
      check("follow_release", {31'd0, bus.led_pad[3]}, {31'd0, prev_b3});
    end

    // Inverted-polarity instance: raw low presses, lit LED drives the pad low.
    check("inv_idle_pad", {28'd0, bus2.led_pad}, 32'h0000000F);
    check("inv_idle_buttons", {28'd0, bus2.buttons}, 32'd0);
    bus2.btn_raw[0] = 1'b0;
    exp_edge  = cyc + 11;
    got_edge  = -1;
    got_press = 4'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (got_edge < 0 && bus2.btn_press != 4'h0) begin
        got_edge  = cyc;
        got_press = bus2.btn_press;
      end
    end
    check("inv_press_edge", got_edge, exp_edge);
    check("inv_press_val", {28'd0, got_press}, 32'd1);
    check("inv_buttons", {28'd0, bus2.buttons}, 32'd1);
    bus2.led_mode[1:0] = 2'b01;
    wait_n(1);
    check("inv_led_on", {28'd0, bus2.led_pad}, 32'h0000000E);

    wait_n(2);
    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
